// File: rtl/costas_ctrl_pkg.sv
// Shared types and constants for the Costas loop lock controller.
package costas_ctrl_pkg;

    localparam int unsigned NCO_W = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_SWEEP = 2'd2,
        ST_TRACK = 2'd3
    } state_e;

    localparam logic [1:0] GAIN_ACQ   = 2'b00;
    localparam logic [1:0] GAIN_TRACK = 2'b01;

    // One sweep step; anything past +limit folds back to -limit.
    function automatic logic signed [NCO_W-1:0] sweep_wrap(
        input logic signed [NCO_W-1:0] cur,
        input logic signed [NCO_W-1:0] step,
        input logic signed [NCO_W-1:0] limit
    );
        logic signed [NCO_W:0] sum;
        sum = (NCO_W+1)'(cur) + (NCO_W+1)'(step);
        if (sum > (NCO_W+1)'(limit)) begin
            sweep_wrap = -limit;
        end else begin
            sweep_wrap = NCO_W'(sum);
        end
    endfunction

endpackage

// File: rtl/pd_abs_accum.sv
// Windowed |pd| accumulator producing the lock metric and a window-done strobe.
module pd_abs_accum #(
    parameter int unsigned DW       = 26,
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       pd_valid_i,
    input  logic signed [DW-1:0]       pd_i,
    output logic [DW+WIN_LOG2-1:0]     metric_o,
    output logic                       win_done_o
);

    localparam int unsigned MW = DW + WIN_LOG2;
    localparam logic [DW-1:0] PD_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [DW-2:0]       abs_c;
    logic [MW-1:0]       sum_c;
    logic [MW-1:0]       acc_q,    acc_d;
    logic [MW-1:0]       metric_q, metric_d;
    logic [WIN_LOG2-1:0] cnt_q,    cnt_d;
    logic                done_q,   done_d;

    // Magnitude with the most-negative code saturated to the largest positive value.
    always_comb begin
        abs_c = pd_i[DW-2:0];
        if (pd_i == PD_MIN) begin
            abs_c = {(DW-1){1'b1}};
        end else if (pd_i[DW-1]) begin
            abs_c = (DW-1)'(-pd_i);
        end
    end

    assign sum_c = acc_q + MW'(abs_c);

    // Window bookkeeping: last sample loads the metric and restarts the sum.
    always_comb begin
        acc_d    = acc_q;
        metric_d = metric_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pd_valid_i) begin
            cnt_d = cnt_q + WIN_LOG2'(1);
            if (&cnt_q) begin
                metric_d = sum_c;
                acc_d    = '0;
                done_d   = 1'b1;
            end else begin
                acc_d = sum_c;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            metric_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            metric_q <= metric_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign metric_o   = metric_q;
    assign win_done_o = done_q;

endmodule

// File: rtl/costas_lock_ctrl.sv
// Costas loop lock controller: acquisition / tracking FSM with optional
// NCO frequency sweep, enabled by defining COSTAS_SWEEP_EN.
module costas_lock_ctrl
    import costas_ctrl_pkg::*;
#(
    parameter int unsigned              DW          = 26,
    parameter int unsigned              WIN_LOG2    = 10,
    parameter int unsigned              LOCK_CNT    = 4,
    parameter int unsigned              UNLOCK_CNT  = 2,
    parameter int unsigned              ACQ_WIN     = 16,
    parameter logic signed [NCO_W-1:0]  SWEEP_STEP  = 30'sd13422,
    parameter logic signed [NCO_W-1:0]  SWEEP_LIMIT = 30'sd268440
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        pd_valid,
    input  logic signed [DW-1:0]        pd,
    input  logic [DW+WIN_LOG2-1:0]      lock_thr,
    input  logic [DW+WIN_LOG2-1:0]      unlock_thr,
    output logic [1:0]                  gain_sel,
    output logic                        integ_clr,
    output logic signed [NCO_W-1:0]     freq_offset,
    output logic                        locked,
    output logic [DW+WIN_LOG2-1:0]      metric
);

    localparam int unsigned MW = DW + WIN_LOG2;
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

    state_e         state_q, state_d;
    logic [1:0]     gain_q,   gain_d;
    logic           locked_q, locked_d;
    logic           clr_q,    clr_d;
    logic [GW-1:0]  good_q,   good_d;
    logic [BW-1:0]  bad_q,    bad_d;
    logic [MW-1:0]  metric_c;
    logic           win_done_c;
`ifdef COSTAS_SWEEP_EN
    localparam int unsigned AW = $clog2(ACQ_WIN + 1);
    logic [AW-1:0]              acq_q,  acq_d;
    logic signed [NCO_W-1:0]    freq_q, freq_d;
`endif

    pd_abs_accum #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == ST_IDLE),
        .pd_valid_i (pd_valid),
        .pd_i       (pd),
        .metric_o   (metric_c),
        .win_done_o (win_done_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        locked_d = locked_q;
        clr_d    = 1'b0;
        good_d   = good_q;
        bad_d    = bad_q;
`ifdef COSTAS_SWEEP_EN
        acq_d    = acq_q;
        freq_d   = freq_q;
`endif
        if (!enable) begin
            state_d  = ST_IDLE;
            gain_d   = GAIN_ACQ;
            locked_d = 1'b0;
            good_d   = '0;
            bad_d    = '0;
`ifdef COSTAS_SWEEP_EN
            acq_d    = '0;
            freq_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ACQ;
                    gain_d   = GAIN_ACQ;
                    locked_d = 1'b0;
                    clr_d    = 1'b1;
                end
                ST_ACQ: begin
                    if (win_done_c) begin
                        good_d = (metric_c < lock_thr) ? good_q + GW'(1) : '0;
                        if (good_d == GW'(LOCK_CNT)) begin
                            state_d  = ST_TRACK;
                            gain_d   = GAIN_TRACK;
                            locked_d = 1'b1;
                            good_d   = '0;
                            bad_d    = '0;
`ifdef COSTAS_SWEEP_EN
                            acq_d    = '0;
                        end else begin
                            acq_d = acq_q + AW'(1);
                            if (acq_d == AW'(ACQ_WIN)) begin
                                state_d = ST_SWEEP;
                            end
`endif
                        end
                    end
                end
`ifdef COSTAS_SWEEP_EN
                ST_SWEEP: begin
                    freq_d  = sweep_wrap(freq_q, SWEEP_STEP, SWEEP_LIMIT);
                    clr_d   = 1'b1;
                    good_d  = '0;
                    bad_d   = '0;
                    acq_d   = '0;
                    state_d = ST_ACQ;
                end
`endif
                ST_TRACK: begin
                    if (win_done_c) begin
                        bad_d = (metric_c >= unlock_thr) ? bad_q + BW'(1) : '0;
                        if (bad_d == BW'(UNLOCK_CNT)) begin
                            state_d  = ST_ACQ;
                            gain_d   = GAIN_ACQ;
                            locked_d = 1'b0;
                            clr_d    = 1'b1;
                            good_d   = '0;
                            bad_d    = '0;
`ifdef COSTAS_SWEEP_EN
                            acq_d    = '0;
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gain_q   <= GAIN_ACQ;
            locked_q <= 1'b0;
            clr_q    <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
`ifdef COSTAS_SWEEP_EN
            acq_q    <= '0;
            freq_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            locked_q <= locked_d;
            clr_q    <= clr_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
`ifdef COSTAS_SWEEP_EN
            acq_q    <= acq_d;
            freq_q   <= freq_d;
`endif
        end
    end

    assign gain_sel  = gain_q;
    assign locked    = locked_q;
    assign integ_clr = clr_q;
    assign metric    = metric_c;
`ifdef COSTAS_SWEEP_EN
    assign freq_offset = freq_q;
`else
    assign freq_offset = '0;
`endif

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed bench for costas_lock_ctrl (WIN_LOG2=4, LOCK_CNT=2, UNLOCK_CNT=2, ACQ_WIN=3).
module tb_costas_lock_ctrl;

    localparam int unsigned DW = 26;
    localparam int unsigned WL = 4;
    localparam int unsigned MW = DW + WL;

`ifdef COSTAS_SWEEP_EN
    localparam longint EXP_F1    = 13422;
    localparam longint EXP_FMAX  = 268440;
    localparam longint EXP_FWRAP = -268440;
    localparam longint EXP_FNEXT = -255018;
    localparam longint EXP_SCLR  = 1;
`else
    localparam longint EXP_F1    = 0;
    localparam longint EXP_FMAX  = 0;
    localparam longint EXP_FWRAP = 0;
    localparam longint EXP_FNEXT = 0;
    localparam longint EXP_SCLR  = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 pd_valid;
    logic signed [DW-1:0] pd;
    logic [MW-1:0]        lock_thr;
    logic [MW-1:0]        unlock_thr;
    logic [1:0]           gain_sel;
    logic                 integ_clr;
    logic signed [29:0]   freq_offset;
    logic                 locked;
    logic [MW-1:0]        metric;

    int errors = 0;
    int checks = 0;

    costas_lock_ctrl #(
        .DW         (DW),
        .WIN_LOG2   (WL),
        .LOCK_CNT   (2),
        .UNLOCK_CNT (2),
        .ACQ_WIN    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pd_valid    (pd_valid),
        .pd          (pd),
        .lock_thr    (lock_thr),
        .unlock_thr  (unlock_thr),
        .gain_sel    (gain_sel),
        .integ_clr   (integ_clr),
        .freq_offset (freq_offset),
        .locked      (locked),
        .metric      (metric)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        pd_valid   = 1'b0;
        pd         = '0;
        lock_thr   = MW'(100);
        unlock_thr = MW'(1000);

        // Reset state
        #2;
        check("rst_gain",   gain_sel,    0);
        check("rst_clr",    integ_clr,   0);
        check("rst_freq",   freq_offset, 0);
        check("rst_locked", locked,      0);
        check("rst_metric", metric,      0);

        // Released but disabled: stays idle
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("idle_clr",  integ_clr, 0);
        check("idle_gain", gain_sel,  0);

        // Enable: one-cycle integrator clear into ACQ
        enable = 1'b1;
        tick(1);
        check("en_clr",    integ_clr,   1);
        check("en_gain",   gain_sel,    0);
        check("en_freq",   freq_offset, 0);
        check("en_locked", locked,      0);
        pd = 26'sd5;
        pd_valid = 1'b1;
        tick(1);
        check("en_clr_off", integ_clr, 0);

        // pd=+5: two good windows then lock
        tick(15);
        check("w1_metric", metric, 80);
        check("w1_locked", locked, 0);
        tick(16);
        check("w2_metric", metric, 80);
        check("w2_locked", locked, 0);
        tick(1);
        check("lock_locked", locked,   1);
        check("lock_gain",   gain_sel, 1);

        // TRACK with pd=+100: two bad windows drop lock
        pd = 26'sd100;
        tick(15);
        check("t1_metric", metric, 1505);
        check("t1_locked", locked, 1);
        tick(16);
        check("t2_metric", metric, 1600);
        check("t2_locked", locked, 1);
        pd = {1'b1, {(DW-1){1'b0}}};
        tick(1);
        check("unlock_locked", locked,      0);
        check("unlock_gain",   gain_sel,    0);
        check("unlock_clr",    integ_clr,   1);
        check("unlock_freq",   freq_offset, 0);
        tick(1);
        check("unlock_clr_off", integ_clr, 0);

        // Most-negative pd: saturated magnitude, never locks, sweeps
        tick(14);
        check("sat_metric", metric, 64'd536870896);
        check("sat_locked", locked, 0);
        tick(33);
        check("pre_sweep_freq", freq_offset, 0);
        check("pre_sweep_clr",  integ_clr,   0);
        tick(1);
        check("sweep1_freq", freq_offset, EXP_F1);
        check("sweep1_clr",  integ_clr,   EXP_SCLR);
        tick(1);
        check("sweep1_clr_off", integ_clr, 0);
        tick(911);
        check("sweep20_freq", freq_offset, EXP_FMAX);
        check("sweep20_clr",  integ_clr,   EXP_SCLR);
        tick(48);
        check("sweep21_wrap", freq_offset, EXP_FWRAP);
        tick(48);
        check("sweep22_freq",   freq_offset, EXP_FNEXT);
        check("sweep22_locked", locked,      0);

        // Disable: idle clears the offset
        enable = 1'b0;
        tick(1);
        check("dis_freq",   freq_offset, 0);
        check("dis_locked", locked,      0);
        check("dis_clr",    integ_clr,   0);

        // Enable drop coincident with a lock-qualifying window-done
        pd = 26'sd5;
        enable = 1'b1;
        tick(1);
        check("re_en_clr", integ_clr, 1);
        tick(32);
        check("race_metric", metric, 80);
        check("race_locked", locked, 0);
        enable = 1'b0;
        tick(1);
        check("race_idle_locked", locked,   0);
        check("race_idle_gain",   gain_sel, 0);
        check("race_idle_clr",    integ_clr, 0);
        tick(1);
        check("race_idle_locked2", locked, 0);

        // Lock again, then asynchronous reset mid-window
        enable = 1'b1;
        tick(1);
        tick(33);
        check("relock_locked", locked,   1);
        check("relock_gain",   gain_sel, 1);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gain",   gain_sel,    0);
        check("arst_clr",    integ_clr,   0);
        check("arst_freq",   freq_offset, 0);
        check("arst_locked", locked,      0);
        check("arst_metric", metric,      0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_clr",    integ_clr, 1);
        check("post_rst_locked", locked,    0);
        check("post_rst_metric", metric,    0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/costas_lock_ctrl.md
COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

Interface
REQ-001 SHALL have parameter DW, default 26: width of the phase-detector sample.
REQ-002 SHALL have parameter WIN_LOG2, default 10: log2 of the lock-metric window length in valid samples.
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive good windows required to declare lock.
REQ-004 SHALL have parameter UNLOCK_CNT, default 2: consecutive bad windows required to drop lock.
REQ-005 SHALL have parameter ACQ_WIN, default 16: windows allowed in ACQ before a frequency sweep step.
REQ-006 SHALL have parameter SWEEP_STEP, default 30'sd13422: NCO offset added per sweep step (100 Hz at 8 MHz).
REQ-007 SHALL have parameter SWEEP_LIMIT, default 30'sd268440: maximum offset magnitude (2 kHz).
REQ-008 SHALL have ports: clk in 1, system clock; rst_n in 1, reset, asynchronous, active-low.
REQ-009 SHALL have ports: enable in 1, run control; pd_valid in 1, pd sample strobe; pd in DW signed, phase-detector output.
REQ-010 SHALL have ports: lock_thr in DW+WIN_LOG2, lock threshold; unlock_thr in DW+WIN_LOG2, unlock threshold.
REQ-011 SHALL have outputs: gain_sel out 2, loop-filter gain code (00 ACQ, 01 TRACK); integ_clr out 1, one-cycle loop-filter integrator clear.
REQ-012 SHALL have outputs: freq_offset out 30 signed, added to the NCO carrier word; locked out 1; metric out DW+WIN_LOG2, last completed window sum.

Function
REQ-013 SHALL form |pd| on each pd_valid; the most-negative pd SHALL saturate to 2^(DW-1)-1.
REQ-014 SHALL accumulate |pd| over 2^WIN_LOG2 valid samples, unsigned, without overflow; on the last sample it SHALL load metric with the sum, clear the accumulator, and raise an internal window-done strobe one cycle later.
REQ-015 SHALL implement states IDLE, ACQ, SWEEP, TRACK.
REQ-016 IDLE: gain_sel=00, locked=0, freq_offset=0, accumulator and counters cleared; on enable=1, go to ACQ and pulse integ_clr.
REQ-017 ACQ: on window-done, metric<lock_thr increments good_cnt, otherwise clears it; when good_cnt reaches LOCK_CNT, go to TRACK; otherwise, after ACQ_WIN windows, go to SWEEP.
REQ-018 SWEEP, one cycle: freq_offset += SWEEP_STEP; a result >SWEEP_LIMIT SHALL wrap to -SWEEP_LIMIT; pulse integ_clr; clear counters; return to ACQ.
REQ-019 TRACK: gain_sel=01, locked=1; on window-done, metric>=unlock_thr increments bad_cnt, otherwise clears it; at UNLOCK_CNT, go to ACQ, locked=0, pulse integ_clr, and retain freq_offset.
REQ-020 gain_sel and locked SHALL be registered and change in the cycle after the state transition; integ_clr SHALL be exactly one cycle wide.
REQ-021 enable=0 in any state SHALL force IDLE on the next clock, overriding a simultaneous window-done.
REQ-022 A pd_valid coincident with a state change SHALL count toward the current window; windows are not restarted except on IDLE.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, with all outputs 0 and the accumulator, window counter, good_cnt, bad_cnt and acq_cnt all 0.
REQ-024 Release of rst_n SHALL take effect on the next rising clk; operation SHALL begin only when enable=1.

Configuration
REQ-025 Macro COSTAS_SWEEP_EN SHALL control sweeping: when defined, SWEEP behaves as stated; when undefined, SWEEP is absent, ACQ persists indefinitely, acq_cnt is removed, and freq_offset is constant 0.

Structure
REQ-026 Package costas_ctrl_pkg SHALL hold the state enum, gain codes GAIN_ACQ/GAIN_TRACK, and NCO width constant 30.
REQ-027 Sub-module pd_abs_accum SHALL implement REQ-013/014, exposing metric and window-done; the FSM resides in costas_lock_ctrl.

Verification (bench: WIN_LOG2=4, LOCK_CNT=2, UNLOCK_CNT=2, ACQ_WIN=3)
REQ-028 Reset, enable 0->1 -> integ_clr high exactly one cycle, then ACQ state with gain_sel=00, freq_offset=0.
REQ-029 pd=+5 continuous, lock_thr=100 -> metric=80 each window; locked=1 and gain_sel=01 one cycle after the 2nd window-done.
REQ-030 pd=-2^25 continuous -> metric=16*(2^25-1); no lock; after 3 windows, freq_offset=13422 and integ_clr pulses; repeated steps wrap past 268440 to -268440.
REQ-031 In TRACK, pd=+100 with unlock_thr=1000 -> after 2 bad windows, locked=0, gain_sel=00, integ_clr pulses, freq_offset unchanged.
REQ-032 enable dropped on the same cycle as a lock-qualifying window-done -> IDLE next cycle, locked stays 0; rst_n pulsed mid-window -> all outputs 0 immediately.
